// File: rtl/up_counter_load.sv
// up_counter_load: loadable up-counter with a terminal-count flag.
// Used as a programmable delay/done timer: load a start value, R flags expiry.
//
// Parameters:
//   WIDTH  bit width of val and of the count register
//   WRAP   1 = count wraps max->0, 0 = count saturates at max until a load
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset (count -> 0)
//   val    in   WIDTH  load value, sampled only when load=1
//   load   in   1      synchronous load strobe (beats increment and wrap)
//   R      out  1      terminal count, 1 while count == 2^WIDTH-1
//   count  out  WIDTH  current count register
module up_counter_load #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] val,
    input  logic             load,
    output logic             R,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_at_max;

    assign w_at_max = (r_count == MAX);

    // Load has top priority; at max the count either restarts at 0 or
    // parks at max until the next load.
    always_comb begin
        w_next = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        if (load) begin
            w_next = val;
        end else if (w_at_max) begin
            if (WRAP) begin
                w_next = '0;
            end else begin
                w_next = MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    // Plain decode of the register, so R tracks count with no extra delay.
    assign R     = w_at_max;
    assign count = r_count;

endmodule

// File: tb/tb_up_counter_load.sv
// tb_up_counter_load: scoreboard bench for up_counter_load.
// Drives a WRAP=1 and a WRAP=0 instance from the same stimulus.
module tb_up_counter_load;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] val;
    logic [3:0] c1, c0;
    logic       R1, R0;

    always #5 clk = ~clk;

    up_counter_load #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .val(val), .load(load), .R(R1), .count(c1)
    );

    up_counter_load #(.WIDTH(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .val(val), .load(load), .R(R0), .count(c0)
    );

    typedef struct {
        logic [3:0] c1;
        logic [3:0] c0;
    } exp_t;

    exp_t       q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] m1, m0;

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    // Monitor: each falling edge, compare against the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wrap count", c1, e.c1);
                chk("wrap R", {3'b000, R1}, {3'b000, e.c1 == 4'hF});
                chk("sat count", c0, e.c0);
                chk("sat R", {3'b000, R0}, {3'b000, e.c0 == 4'hF});
            end
        end
    end

    // One clock of stimulus; the expected post-edge counts go on the queue.
    task automatic step(input logic l, input logic [3:0] v);
        @(negedge clk);
        load = l;
        val  = v;
        @(posedge clk);
        #1;
        if (l) begin
            m1 = v;
            m0 = v;
        end else begin
            m1 = (m1 == 4'hF) ? 4'h0 : m1 + 4'd1;
            m0 = (m0 == 4'hF) ? 4'hF : m0 + 4'd1;
        end
        q.push_back('{c1: m1, c0: m0});
    endtask

    // Reset pulse of half a period, starting between edges.
    task automatic areset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst wrap count", c1, 4'h0);
        chk("async rst wrap R", {3'b000, R1}, 4'h0);
        chk("async rst sat count", c0, 4'h0);
        chk("async rst sat R", {3'b000, R0}, 4'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m1  = 4'h0;
        m0  = 4'h0;
    endtask

    initial begin : driver
        rst  = 1'b1;
        load = 1'b1;
        val  = 4'd5;
        m1   = 4'h0;
        m0   = 4'h0;
        #1;
        chk("reset wrap count", c1, 4'h0);
        chk("reset wrap R", {3'b000, R1}, 4'h0);
        chk("reset sat count", c0, 4'h0);
        chk("reset sat R", {3'b000, R0}, 4'h0);
        // load stays high across the release edge and must be ignored
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // free run 1..15 then wrap (sat instance parks at 15)
        repeat (16) step(1'b0, 4'd0);

        // load 7: 8..15 over 8 edges, then wrap to 0
        step(1'b1, 4'd7);
        repeat (9) step(1'b0, 4'd0);

        // load max: sat instance holds R for 11 cycles, then load 3
        step(1'b1, 4'd15);
        repeat (11) step(1'b0, 4'd0);
        step(1'b1, 4'd3);
        step(1'b0, 4'd0);

        // load beats wrap on the count==max edge
        step(1'b1, 4'd14);
        step(1'b0, 4'd0);
        step(1'b1, 4'd2);
        step(1'b0, 4'd0);

        // held load of 9 for 5 edges, then 10
        repeat (5) step(1'b1, 4'd9);
        step(1'b0, 4'd0);

        // reach 12, reset mid-count, resume 1,2,3
        step(1'b1, 4'd11);
        step(1'b0, 4'd0);
        areset();
        repeat (3) step(1'b0, 4'd0);

        // bounded drain of the scoreboard
        repeat (4) begin
            if (q.size() > 0) @(negedge clk);
        end
        #1;
        chk("scoreboard drained", 4'(q.size()), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/up_counter_load.md
Name: up_counter_load

Overview:
- Loadable up-counter with a terminal-count flag; clock `clk`, asynchronous active-high reset `rst`.
- Counts up by one every `clk` rising edge from a value loaded on `val`/`load`.
- Asserts `R` while the count sits at its all-ones maximum.
- Used in the dynamic-adder datapath as a programmable delay/done timer: load a start value, `R` flags expiry.

Parameters:
- WIDTH, 4, bit width of `val` and the internal count.
- WRAP, 1, 1 = count wraps max->0; 0 = count saturates at max until the next load.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- val  input  WIDTH  load value, sampled only when `load`=1.
- load  input  1  synchronous load strobe.
- R  output  1  terminal-count flag, 1 when count == 2^WIDTH-1.
- count  output  WIDTH  current count register, for observation/debug.
- Instantiations connect by name; `clk`, `val`, `load`, `R` keep these names.

Behaviour:
- Reset: `rst`=1 immediately (asynchronously) forces count=0 and R=0, independent of `clk`. It holds while `rst` is high. Deassertion is sampled normally at the next rising edge.
- Each rising `clk` edge with `rst`=0, in priority order:
  - `load`=1: count <= `val`. Load beats increment and wrap.
  - count != max: count <= count+1.
  - count == max and WRAP=1: count <= 0.
  - count == max and WRAP=0: count holds max.
- `R` is a combinational decode of the count register: R = (count == 2^WIDTH-1).
  - No extra register stage; `R` changes with `count`, one edge after the causing event.
- Load latency: `val` appears on `count` after the edge at which `load`=1 is sampled.
  - Loading `val`=max raises R in that same cycle.
- Expiry timing: after loading value v, R rises exactly (max - v) edges after the load edge.
  - Example: WIDTH=4, v=7 -> 8 further edges.
- WRAP=1: R is high for exactly one cycle per pass, then count restarts at 0 and R falls.
- WRAP=0: R stays high until reset or a load of a value != max.
- `load` held high for several edges: count re-loads `val` every edge, no increment.
- `load` and count==max in the same cycle: load wins, and R follows the loaded value.
- Reset mid-count or mid-load: the count is discarded and becomes 0. A `load` pending on the reset-release edge is ignored.
- `load`=X/Z is not a legal input. After reset the block depends only on a driven `load`.
- Arithmetic is unsigned modulo 2^WIDTH. No carry or overflow output.

Test Plan:
- Reset: assert `rst` between clock edges -> count=0 and R=0 immediately. Release, idle 16 edges (WRAP=1) -> count runs 0..15, R=1 only at 15, then wraps to 0.
- Load 7: `load`=1 with `val`=7 for one edge, then `load`=0 -> count=7 next cycle, 8..15 over 8 edges, R=1 when count=15, R=0 the following edge (count=0).
- Load max: `val`=15 loaded -> R=1 on the cycle after the load edge. Same test with WRAP=0 -> R stays 1 for 10+ cycles; a later load of 3 -> R=0 and count=3.
- Load priority: `load`=1 with `val`=2 on the edge where count=15 -> count=2 (not 0), R=0.
- Held load: `load`=1 for 5 edges with `val`=9 -> count stays 9, R=0. After release, count=10 next edge.
- Async reset mid-count: count=12, pulse `rst` for half a clock period -> count=0 instantly. Counting resumes 1,2,... after release.
